// File: rtl/pe_out_pkg.sv
// Shared types for the PE array output collector.
// Beat layout, serializer states and array geometry constants.
package pe_out_pkg;

    localparam int PE_ROWS = 2;
    localparam int PE_COLS = 16;
    localparam int PE_DW   = 16;
    localparam int TAG_W   = 4;

    typedef struct packed {
        logic [TAG_W-1:0]                         tag;
        logic [PE_ROWS-1:0][PE_COLS-1:0][PE_DW-1:0] data;
    } pe_beat_t;

    typedef enum logic {
        ROW0 = 1'b0,
        ROW1 = 1'b1
    } ser_state_e;

endpackage

// File: rtl/pe_out_collector_if.sv
// Beat input and row output stream of the collector.
// slave = collector side, master = array/writeback side.
interface pe_out_collector_if
    import pe_out_pkg::*;
#(
    parameter int ROWS = PE_ROWS,
    parameter int COLS = PE_COLS,
    parameter int DW   = PE_DW
);
    logic [ROWS*COLS*DW-1:0] pe_data;
    logic                    pe_valid;
    logic [TAG_W-1:0]        pe_tag;

    logic [COLS*DW-1:0]      out_data;
    logic                    out_row;
    logic [TAG_W-1:0]        out_tag;
    logic                    out_last;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output pe_data, pe_valid, pe_tag, out_ready,
        input  out_data, out_row, out_tag, out_last, out_valid
    );

    modport slave (
        input  pe_data, pe_valid, pe_tag, out_ready,
        output out_data, out_row, out_tag, out_last, out_valid
    );
endinterface

// File: rtl/pe_out_fifo.sv
// Show-ahead beat FIFO with registered, reset storage.
// A push into a full FIFO is taken only alongside a pop.
module pe_out_fifo
    import pe_out_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  pe_beat_t      wdata,
    output pe_beat_t      rdata,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);
    pe_beat_t      mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_q];
    assign level   = level_q;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (do_push) mem_q[wr_q] <= wdata;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end
endmodule

// File: rtl/pe_out_collector.sv
// Buffers PE array result beats and streams them out one row per transfer.
// Beats arriving with the FIFO full and no pop are dropped and flagged.
module pe_out_collector
    import pe_out_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter int  ROWS  = PE_ROWS,
    parameter int  COLS  = PE_COLS,
    parameter int  DW    = PE_DW,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    pe_out_collector_if.slave bus,
    output logic [LW-1:0]     level,
    output logic              overflow,
    input  logic              clr_overflow
);
    ser_state_e              state_q, state_d;
    logic                    overflow_q, overflow_d;
    pe_beat_t                wr_beat, head;
    logic                    full, empty;
    logic                    hs, push, pop, drop;
    logic [ROWS*COLS*DW-1:0] beat_w;
    logic [COLS*DW-1:0]      row_w;
    logic [LW-1:0]           fifo_level;

    assign beat_w  = bus.pe_data;
    assign wr_beat = {bus.pe_tag, beat_w};

    pe_out_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wr_beat),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    // A pop frees a slot in the same edge, so a full FIFO still takes a beat.
    always_comb begin
        state_d    = state_q;
        overflow_d = overflow_q;
        hs         = !empty && bus.out_ready;
        pop        = hs && (state_q == ROW1);
        push       = bus.pe_valid && (!full || pop);
        drop       = bus.pe_valid && full && !pop;
        unique case (state_q)
            ROW0: if (hs) state_d = ROW1;
            ROW1: if (hs) state_d = ROW0;
        endcase
        if (clr_overflow) overflow_d = 1'b0;
        if (drop)         overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ROW0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
        end
    end

    assign row_w         = (state_q == ROW1) ? head.data[1] : head.data[0];
    assign bus.out_data  = row_w;
    assign bus.out_row   = (state_q == ROW1);
    assign bus.out_last  = (state_q == ROW1);
    assign bus.out_tag   = head.tag;
    assign bus.out_valid = !empty;
    assign level         = fifo_level;
    assign overflow      = overflow_q;
endmodule

// File: doc/pe_out_collector.md
# pe_out_collector

Downstream stage of the 2×16 PE array. Captures each rounded result beat (two rows of sixteen 16-bit fixed-point values, tagged with the round number) into a small FIFO. It then serializes each beat onto a 256-bit valid/ready stream, one row per transfer, for the writeback/output buffer. It absorbs the array's fire-and-forget output, which has no backpressure, and reports overflow.

## Interface
Parameters:
- DEPTH, 4: FIFO entries (beats); power of two, ≥2.
- ROWS, 2: PE rows per beat; fixed by the array.
- COLS, 16: PEs per row.
- DW, 16: element width (Q7.9).

Ports:
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- pe_data  in  ROWS*COLS*DW (512)  array result; element (m,n) at bits [(m*COLS+n)*DW +: DW].
- pe_valid  in  1  array rounder_valid; one beat per high cycle.
- pe_tag  in  4  array round_number for the beat.
- out_data  out  COLS*DW (256)  one row; element n at [n*DW +: DW].
- out_row  out  1  row index of out_data (0 first).
- out_tag  out  4  tag of the beat being emitted.
- out_last  out  1  high on the final row (row 1) of a beat.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- level  out  $clog2(DEPTH)+1  entries currently stored.
- overflow  out  1  sticky; a beat was dropped.
- clr_overflow  in  1  clears overflow.

## Operation
- Push: pe_valid=1 writes {pe_tag, pe_data} at the write pointer. The push is accepted if level<DEPTH, or if level==DEPTH and a pop completes in the same cycle.
- Drop: pe_valid=1, FIFO full, and no pop that cycle. The beat is discarded, overflow is set, and pointers and level are unchanged.
- Head serializer has two states, ROW0 and ROW1:
  - ROW0: out_data = head row 0, out_row=0, out_last=0. A handshake (out_valid&&out_ready) moves to ROW1.
  - ROW1: out_data = head row 1, out_row=1, out_last=1. A handshake pops the head and returns to ROW0.
- out_valid = (level≠0).
- While out_valid=1 and out_ready=0, out_data, out_row, out_tag and out_last are held stable.
- Pointers wrap modulo DEPTH. level = writes − pops; it increments, decrements, or holds when a push and a pop occur together.
- overflow: set by a drop, cleared by clr_overflow. If both occur in the same cycle, set wins.
- Reset values: level=0, out_valid=0, state ROW0 (out_row=0, out_last=0), overflow=0, pointers=0. out_data and out_tag are don't-care while out_valid=0, but the bench checks them as 0 after reset (FIFO storage is reset).
- Reset mid-stream: all stored beats are discarded. A pe_valid in the reset cycle is ignored.
- No reordering. Tags pass through unchecked.

## Timing
- Push latency: pe_valid in cycle N gives out_valid=1 with row 0 of that beat in cycle N+1, provided the FIFO was empty.
- Sustained throughput is 1 beat per 2 cycles when out_ready=1 continuously. The array may burst at 1 beat/cycle; bursts longer than about DEPTH+burst/2 beats overflow.
- A pop and a push in the same cycle take effect together at the clock edge. level is registered.
- out_valid never depends combinationally on out_ready.
- The path from out_ready to the state and pointer update is registered; there is no combinational out_ready→out_valid path.

## Structure
- Package pe_out_pkg holds:
  - constants PE_ROWS=2, PE_COLS=16, PE_DW=16, TAG_W=4;
  - typedef pe_beat_t = struct {tag, [ROWS-1:0][COLS-1:0][DW-1:0] data};
  - enum ser_state_e {ROW0, ROW1}.
- Sub-module pe_out_fifo is a synchronous show-ahead FIFO of pe_beat_t with push, pop, full, empty, level and a registered memory.
- The top level is the serializer FSM plus overflow logic.

## Test plan
- Single beat: tag=3, row0 elements 0x0001..0x0010, row1 elements 0x0101..0x0110, out_ready=1. Required: cycle N+1 row0 with out_last=0; cycle N+2 row1 with out_tag=3 and out_last=1; then out_valid=0 and level=0.
- Backpressure: push one beat and hold out_ready=0 for 5 cycles. Required: out_data, out_row and out_tag stable with out_valid=1. Release out_ready and the two rows transfer in order.
- Overflow (DEPTH=4): out_ready=0 and 6 back-to-back beats with tags 0..5. Required: level=4, overflow=1, and the stream later delivers only tags 0,1,2,3, in order.
- Full push+pop: FIFO full and in ROW1 with out_ready=1, plus pe_valid with tag 9 in the same cycle. Required: the beat is accepted, level stays 4, overflow stays 0, and tag 9 emerges last.
- Wrap-around: 20 beats at 1 beat per 2 cycles with out_ready=1. Required: all 40 rows delivered, tags in order, level ≤1.
- Reset mid-stream: 3 beats queued and in ROW1, rst for 1 cycle. Required: next cycle out_valid=0, level=0, overflow=0, out_row=0. clr_overflow and a drop in the same cycle leave overflow=1.
